// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scancode decoder and per-key state tracker fed from a FWFT byte FIFO.
// Optional auto-repeat of the most recently pressed key when KEY_TRACKER_REPEAT_EN is defined.
module ps2_key_tracker #(
  parameter int unsigned NUM_KEYS     = 4,
  parameter int unsigned REPEAT_DELAY = 12_500_000,
  parameter int unsigned REPEAT_RATE  = 2_500_000,
  parameter int unsigned CNT_W        = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [7:0]            fifo_data,
  output logic                  fifo_rd,
  input  logic                  clr,
  input  logic [9*NUM_KEYS-1:0] key_codes,
  output logic [NUM_KEYS-1:0]   key_held,
  output logic [NUM_KEYS-1:0]   key_press,
  output logic [NUM_KEYS-1:0]   key_release,
  output logic                  ev_valid,
  output logic [7:0]            ev_code,
  output logic                  ev_ext,
  output logic                  ev_break
);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StSkip} state_e;

  state_e state_q, state_d;
  logic ext_q, ext_d, brk_q, brk_d;
  logic [2:0] skip_q, skip_d;
  logic rd_q, run_q, take, emit;
  logic [NUM_KEYS-1:0] match, press_ev, rel_ev, held_q, held_d, rep_pulse;
  logic [NUM_KEYS-1:0] press_q, release_q;
  logic ev_valid_q, ev_ext_q, ev_break_q;
  logic [7:0] ev_code_q;

  // run_q keeps the pop strobe low while and just after reset is asserted.
  assign fifo_rd = run_q & ~fifo_empty & ~rd_q;
  assign take    = fifo_rd & ~clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= 1'b0;
      run_q <= 1'b0;
    end else begin
      rd_q  <= fifo_rd;
      run_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    if (take) begin
      unique case (state_q)
        StIdle: begin
          case (fifo_data)
            8'hE0: begin ext_d = 1'b1; state_d = StExt; end
            8'hF0: begin brk_d = 1'b1; state_d = StBrk; end
            8'hE1: begin skip_d = 3'd7; state_d = StSkip; end
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
            default: emit = 1'b1;
          endcase
        end
        StExt: begin
          case (fifo_data)
            8'hF0: begin brk_d = 1'b1; state_d = StBrk; end
            8'hE0: ;
            default: emit = 1'b1;
          endcase
        end
        StBrk: emit = 1'b1;
        StSkip: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = StIdle;
        end
      endcase
      if (emit) begin
        state_d = StIdle;
        ext_d   = 1'b0;
        brk_d   = 1'b0;
      end
    end
  end

  // Every matching table entry updates, so duplicate entries behave as aliases.
  always_comb begin
    match = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      match[i] = emit && (key_codes[9*i +: 9] == {ext_q, fifo_data});
    end
    press_ev = match & ~held_q & {NUM_KEYS{~brk_q}};
    rel_ev   = match & held_q & {NUM_KEYS{brk_q}};
    held_d   = (held_q | press_ev) & ~rel_ev;
  end

`ifdef KEY_TRACKER_REPEAT_EN
  localparam int unsigned IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam logic [CNT_W-1:0] CntOne   = 1;
  localparam logic [CNT_W-1:0] DelayLd  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RateLd   = CNT_W'(REPEAT_RATE - 1);

  logic rep_on_q, rep_on_d;
  logic [IDX_W-1:0] rep_idx_q, rep_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    rep_on_d  = rep_on_q;
    rep_idx_d = rep_idx_q;
    cnt_d     = cnt_q;
    rep_pulse = '0;
    if (rep_on_q) begin
      if (cnt_q == '0) begin
        rep_pulse[rep_idx_q] = 1'b1;
        cnt_d = RateLd;
      end else begin
        cnt_d = cnt_q - CntOne;
      end
      if (rel_ev[rep_idx_q]) begin
        rep_on_d  = 1'b0;
        rep_pulse = '0;
      end
    end
    // A fresh press takes over the repeat slot and restarts the delay.
    if (|press_ev) begin
      rep_pulse = '0;
      rep_on_d  = 1'b1;
      cnt_d     = DelayLd;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        if (press_ev[i]) rep_idx_d = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_on_q  <= 1'b0;
      rep_idx_q <= '0;
      cnt_q     <= '0;
    end else if (clr) begin
      rep_on_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      rep_on_q  <= rep_on_d;
      rep_idx_q <= rep_idx_d;
      cnt_q     <= cnt_d;
    end
  end
`else
  assign rep_pulse = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skip_q     <= '0;
      held_q     <= '0;
      press_q    <= '0;
      release_q  <= '0;
      ev_valid_q <= 1'b0;
      ev_code_q  <= '0;
      ev_ext_q   <= 1'b0;
      ev_break_q <= 1'b0;
    end else if (clr) begin
      state_q    <= StIdle;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skip_q     <= '0;
      held_q     <= '0;
      press_q    <= '0;
      release_q  <= '0;
      ev_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      skip_q     <= skip_d;
      held_q     <= held_d;
      press_q    <= press_ev | rep_pulse;
      release_q  <= rel_ev;
      ev_valid_q <= emit;
      if (emit) begin
        ev_code_q  <= fifo_data;
        ev_ext_q   <= ext_q;
        ev_break_q <= brk_q;
      end
    end
  end

  assign key_held    = held_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign ev_valid    = ev_valid_q;
  assign ev_code     = ev_code_q;
  assign ev_ext      = ev_ext_q;
  assign ev_break    = ev_break_q;

endmodule
